// File: rtl/master_port_pkg.sv
// Shared defaults and helpers for the bit-serial bus initiator.
// Bus mode encodings and width defaults live here.
package master_port_pkg;

  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 64;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/master_port_if.sv
// Bit-serial system bus: arbiter handshake plus serial data lanes.
// master: mbreq/mwdata/mmode/mvalid out; slave: grant + slave lanes out.
interface master_port_if;

  logic mbreq;
  logic mbgrant;
  logic mwdata;
  logic mmode;
  logic mvalid;
  logic srdata;
  logic svalid;
  logic sready;

  modport master (
    output mbreq, mwdata, mmode, mvalid,
    input  mbgrant, srdata, svalid, sready
  );

  modport slave (
    input  mbreq, mwdata, mmode, mvalid,
    output mbgrant, srdata, svalid, sready
  );

endinterface

// File: rtl/master_port.sv
// Bus initiator: takes one parallel request, wins the bus, shifts out
// addr/wdata LSB-first and assembles serial read data.
// Ports: clk, rstn (sync, active-low); device side dvalid/dwen/daddr/
// dwdata in, dready/drdata/ddone/derr out; bus via master_port_if.master.
module master_port
  import master_port_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  input  logic                  dwen,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  derr,
  master_port_if.master         bus
);

  localparam int CW =
    $clog2(max3(ADDR_WIDTH, DATA_WIDTH, TIMEOUT)) + 1;

  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [2:0] {
    IDLE, REQ, ADDR, WDATA, RWAIT, RDATA, WACK, DONE
  } state_t;

  state_t                st;
  logic [ADDR_WIDTH-1:0] ash;
  logic [DATA_WIDTH-1:0] wsh;
  logic [DATA_WIDTH-1:0] rsh;
  logic [CW-1:0]         cnt;
  logic                  wen;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st         <= IDLE;
      ash        <= '0;
      wsh        <= '0;
      rsh        <= '0;
      cnt        <= '0;
      wen        <= MODE_READ;
      dready     <= 1'b1;
      drdata     <= '0;
      ddone      <= 1'b0;
      derr       <= 1'b0;
      bus.mbreq  <= 1'b0;
      bus.mwdata <= 1'b0;
      bus.mmode  <= MODE_READ;
      bus.mvalid <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (dvalid) begin
            ash       <= daddr;
            wsh       <= dwdata;
            wen       <= dwen;
            dready    <= 1'b0;
            bus.mbreq <= 1'b1;
            bus.mmode <= dwen;
            st        <= REQ;
          end
        end
        REQ: begin
          if (bus.mbgrant && bus.sready) begin
            bus.mvalid <= 1'b1;
            bus.mwdata <= ash[0];
            ash        <= ash >> 1;
            cnt        <= '0;
            st         <= ADDR;
          end
        end
        ADDR: begin
          if (cnt == A_LAST) begin
            cnt <= '0;
            if (wen == MODE_WRITE) begin
              // Data follows the address with no gap in mvalid.
              bus.mwdata <= wsh[0];
              wsh        <= wsh >> 1;
              st         <= WDATA;
            end else begin
              bus.mvalid <= 1'b0;
              bus.mwdata <= 1'b0;
              st         <= RWAIT;
            end
          end else begin
            cnt        <= cnt + ONE;
            bus.mwdata <= ash[0];
            ash        <= ash >> 1;
          end
        end
        WDATA: begin
          if (cnt == D_LAST) begin
            cnt        <= '0;
            bus.mvalid <= 1'b0;
            bus.mwdata <= 1'b0;
            st         <= WACK;
          end else begin
            cnt        <= cnt + ONE;
            bus.mwdata <= wsh[0];
            wsh        <= wsh >> 1;
          end
        end
        WACK: begin
          if (bus.sready) begin
            cnt       <= '0;
            ddone     <= 1'b1;
            bus.mbreq <= 1'b0;
            st        <= DONE;
          end else if (cnt == T_LAST) begin
            cnt       <= '0;
            ddone     <= 1'b1;
            derr      <= 1'b1;
            bus.mbreq <= 1'b0;
            st        <= DONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RWAIT: begin
          // First valid bit is taken in the same cycle it appears.
          if (bus.svalid) begin
            rsh <= {bus.srdata, rsh[DATA_WIDTH-1:1]};
            cnt <= ONE;
            st  <= RDATA;
          end else if (cnt == T_LAST) begin
            cnt       <= '0;
            ddone     <= 1'b1;
            derr      <= 1'b1;
            bus.mbreq <= 1'b0;
            st        <= DONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        RDATA: begin
          if (bus.svalid) begin
            rsh <= {bus.srdata, rsh[DATA_WIDTH-1:1]};
            if (cnt == D_LAST) begin
              cnt       <= '0;
              drdata    <= {bus.srdata, rsh[DATA_WIDTH-1:1]};
              ddone     <= 1'b1;
              bus.mbreq <= 1'b0;
              st        <= DONE;
            end else begin
              cnt <= cnt + ONE;
            end
          end
        end
        DONE: begin
          ddone     <= 1'b0;
          derr      <= 1'b0;
          dready    <= 1'b1;
          bus.mmode <= MODE_READ;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: write, read, delayed grant,
// read timeout, reset mid-address, busy strobes, back-to-back.
module tb_master_port;

  logic        clk;
  logic        rstn;
  logic        dvalid;
  logic        dwen;
  logic [11:0] daddr;
  logic [7:0]  dwdata;
  logic        dready;
  logic [7:0]  drdata;
  logic        ddone;
  logic        derr;

  int ntests;
  int nfail;
  int ndone;
  int exp_done;
  logic [7:0] last_rd;

  master_port_if bus ();

  master_port #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(8),
    .TIMEOUT   (64)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .dvalid(dvalid),
    .dwen  (dwen),
    .daddr (daddr),
    .dwdata(dwdata),
    .dready(dready),
    .drdata(drdata),
    .ddone (ddone),
    .derr  (derr),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rstn && ddone === 1'b1) ndone++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(
    input logic        w,
    input logic [11:0] a,
    input logic [7:0]  d
  );
    dwen   = w;
    daddr  = a;
    dwdata = d;
    dvalid = 1'b1;
    step();
    dvalid = 1'b0;
    chk("req_mbreq", bus.mbreq, 1);
    chk("req_dready", dready, 0);
    chk("req_mmode", bus.mmode, w);
  endtask

  task automatic do_write(
    input logic [11:0] a,
    input logic [7:0]  d,
    input int          gdly,
    input bit          noise
  );
    logic [19:0] seq;
    seq = {d, a};
    bus.mbgrant = 1'b0;
    bus.sready  = 1'b1;
    issue(1'b1, a, d);
    for (int k = 0; k < gdly; k++) begin
      chk("wait_mbreq", bus.mbreq, 1);
      chk("wait_mvalid", bus.mvalid, 0);
      step();
    end
    bus.mbgrant = 1'b1;
    step();
    bus.sready  = 1'b0;
    bus.mbgrant = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (noise && i < 6) begin
        dvalid = 1'b1;
        dwen   = 1'b0;
        daddr  = ~a;
      end else begin
        dvalid = 1'b0;
      end
      chk("wr_bit", {bus.mvalid, bus.mwdata}, {1'b1, seq[i]});
      chk("wr_mbreq", bus.mbreq, 1);
      step();
    end
    dvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("wack_mvalid", bus.mvalid, 0);
      chk("wack_ddone", ddone, 0);
      step();
    end
    bus.sready = 1'b1;
    step();
    exp_done++;
    chk("wr_ddone", ddone, 1);
    chk("wr_derr", derr, 0);
    chk("wr_mbreq_drop", bus.mbreq, 0);
    chk("wr_mmode_done", bus.mmode, 1);
    chk("wr_drdata_kept", drdata, last_rd);
    step();
    chk("wr_idle_dready", dready, 1);
    chk("wr_idle_ddone", ddone, 0);
    chk("wr_idle_mmode", bus.mmode, 0);
  endtask

  task automatic do_read(
    input logic [11:0] a,
    input logic [7:0]  rd,
    input bit          noise
  );
    bus.mbgrant = 1'b1;
    bus.sready  = 1'b1;
    bus.svalid  = 1'b0;
    issue(1'b0, a, 8'h00);
    step();
    bus.sready  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      dvalid = noise;
      dwen   = 1'b1;
      daddr  = ~a;
      chk("rd_abit", {bus.mvalid, bus.mwdata}, {1'b1, a[i]});
      step();
    end
    dvalid = 1'b0;
    chk("rwait_mvalid", bus.mvalid, 0);
    chk("rwait_mbreq", bus.mbreq, 1);
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        bus.svalid = 1'b0;
        step();
        chk("rd_gap_ddone", ddone, 0);
      end
      bus.svalid = 1'b1;
      bus.srdata = rd[i];
      step();
    end
    bus.svalid = 1'b0;
    bus.sready = 1'b1;
    exp_done++;
    last_rd = rd;
    chk("rd_ddone", ddone, 1);
    chk("rd_derr", derr, 0);
    chk("rd_drdata", drdata, rd);
    chk("rd_mbreq_drop", bus.mbreq, 0);
    step();
    chk("rd_idle_dready", dready, 1);
    chk("rd_idle_ddone", ddone, 0);
  endtask

  initial begin
    ntests      = 0;
    nfail       = 0;
    ndone       = 0;
    exp_done    = 0;
    last_rd     = 8'h00;
    rstn        = 1'b0;
    dvalid      = 1'b0;
    dwen        = 1'b0;
    daddr       = '0;
    dwdata      = '0;
    bus.mbgrant = 1'b0;
    bus.srdata  = 1'b0;
    bus.svalid  = 1'b0;
    bus.sready  = 1'b1;
    step();
    step();
    chk("rst_dready", dready, 1);
    chk("rst_ddone", ddone, 0);
    chk("rst_derr", derr, 0);
    chk("rst_mbreq", bus.mbreq, 0);
    chk("rst_mvalid", bus.mvalid, 0);
    chk("rst_mmode", bus.mmode, 0);
    chk("rst_drdata", drdata, 0);
    rstn = 1'b1;
    step();

    do_write(12'h5A3, 8'hC7, 0, 1'b0);
    do_read(12'h012, 8'h3C, 1'b0);
    do_write(12'h5A3, 8'hC7, 5, 1'b0);

    // Read with a silent slave: abort exactly 64 cycles into RWAIT.
    bus.mbgrant = 1'b1;
    bus.sready  = 1'b1;
    issue(1'b0, 12'h0AB, 8'h00);
    step();
    bus.sready = 1'b0;
    for (int i = 0; i < 12; i++) step();
    for (int k = 0; k < 64; k++) begin
      chk("tmo_wait_ddone", ddone, 0);
      step();
    end
    exp_done++;
    chk("tmo_ddone", ddone, 1);
    chk("tmo_derr", derr, 1);
    chk("tmo_drdata_kept", drdata, last_rd);
    step();
    chk("tmo_idle_dready", dready, 1);
    chk("tmo_idle_derr", derr, 0);

    // Reset while address bit 4 is on the wire.
    bus.mbgrant = 1'b1;
    bus.sready  = 1'b1;
    issue(1'b1, 12'h5A3, 8'hC7);
    step();
    for (int i = 0; i < 4; i++) step();
    chk("mid_bit4", {bus.mvalid, bus.mwdata}, 2'b10);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    last_rd = 8'h00;
    chk("mid_rst_mvalid", bus.mvalid, 0);
    chk("mid_rst_mbreq", bus.mbreq, 0);
    chk("mid_rst_ddone", ddone, 0);
    chk("mid_rst_dready", dready, 1);
    do_write(12'h3C5, 8'h5A, 0, 1'b0);

    // Busy strobes are dropped; then back-to-back requests.
    do_write(12'hABC, 8'h81, 0, 1'b1);
    do_read(12'hFFF, 8'hA5, 1'b1);
    do_read(12'h001, 8'h7E, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("quiet_mbreq", bus.mbreq, 0);
      chk("quiet_dready", dready, 1);
    end
    chk("ddone_count", ndone, exp_done);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
